axis_window: RTL and testbench

// - Crops a rectangular window out of the AXI4-Stream video produced by the mm2s

---
 rtl/axis_window.sv | 224 ++++++++++++++++++++++
 tb/tb_axis_window.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_window.sv
// axis_window: crops a rectangular window out of an AXI4-Stream video frame and re-tags tuser/tlast.
// Defining AXIS_WINDOW_STAT_EN adds the frame_cnt / sof_err status outputs.
module axis_window #(
   parameter int C_PIXEL_WIDTH = 8,
   parameter int C_IMG_WBITS   = 12,
   parameter int C_IMG_HBITS   = 12
) (
   input  logic                     aclk,
   input  logic                     resetn,
   input  logic                     soft_reset,
   input  logic [C_IMG_WBITS-1:0]   win_left,
   input  logic [C_IMG_HBITS-1:0]   win_top,
   input  logic [C_IMG_WBITS-1:0]   win_width,
   input  logic [C_IMG_HBITS-1:0]   win_height,
   input  logic                     s_axis_tvalid,
   input  logic [C_PIXEL_WIDTH-1:0] s_axis_tdata,
   input  logic                     s_axis_tuser,
   input  logic                     s_axis_tlast,
   output logic                     s_axis_tready,
   output logic                     m_axis_tvalid,
   output logic [C_PIXEL_WIDTH-1:0] m_axis_tdata,
   output logic                     m_axis_tuser,
   output logic                     m_axis_tlast,
`ifdef AXIS_WINDOW_STAT_EN
   output logic [15:0]              frame_cnt,
   output logic                     sof_err,
`endif
   input  logic                     m_axis_tready
);

   localparam int WB = C_IMG_WBITS;
   localparam int HB = C_IMG_HBITS;
   localparam int PW = C_PIXEL_WIDTH;

   localparam logic [WB-1:0] ZERO_W  = {WB{1'b0}};
   localparam logic [HB-1:0] ZERO_H  = {HB{1'b0}};
   localparam logic [WB-1:0] ONE_W   = {{(WB-1){1'b0}}, 1'b1};
   localparam logic [HB-1:0] ONE_H   = {{(HB-1){1'b0}}, 1'b1};
   localparam logic [WB:0]   ZERO_WE = {(WB+1){1'b0}};
   localparam logic [HB:0]   ZERO_HE = {(HB+1){1'b0}};
   localparam logic [WB:0]   ONE_WE  = {{WB{1'b0}}, 1'b1};
   localparam logic [HB:0]   ONE_HE  = {{HB{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   state_t        state_r;
   state_t        state_nxt_s;
   state_t        sof_dest_s;

   logic [WB-1:0] col_r;
   logic [HB-1:0] row_r;
   logic [WB-1:0] left_r;
   logic [HB-1:0] top_r;
   logic [WB:0]   col_end_r;
   logic [HB:0]   row_end_r;

   logic          acc_s;
   logic          sof_s;
   logic          proc_s;
   logic          emit_s;
   logic [WB-1:0] cur_col_s;
   logic [HB-1:0] cur_row_s;
   logic [WB-1:0] eff_left_s;
   logic [HB-1:0] eff_top_s;
   logic [WB:0]   eff_col_end_s;
   logic [HB:0]   eff_row_end_s;
   logic [WB:0]   new_col_end_s;
   logic [HB:0]   new_row_end_s;
   logic          in_win_s;
   logic          first_s;
   logic          last_s;
   logic          row_last_s;
   logic          zero_win_s;

   assign s_axis_tready = resetn & (~m_axis_tvalid | m_axis_tready);
   assign acc_s         = s_axis_tvalid & s_axis_tready;
   assign sof_s         = acc_s & s_axis_tuser;
   assign new_col_end_s = {1'b0, win_left} + {1'b0, win_width};
   assign new_row_end_s = {1'b0, win_top} + {1'b0, win_height};
   assign zero_win_s    = (win_width == ZERO_W) | (win_height == ZERO_H);

   // Position and window that apply to the pixel on the input: a tuser pixel is (0,0) of a fresh window
   always_comb begin
      cur_col_s     = col_r;
      cur_row_s     = row_r;
      eff_left_s    = left_r;
      eff_top_s     = top_r;
      eff_col_end_s = col_end_r;
      eff_row_end_s = row_end_r;
      if (s_axis_tuser) begin
         cur_col_s     = ZERO_W;
         cur_row_s     = ZERO_H;
         eff_left_s    = win_left;
         eff_top_s     = win_top;
         eff_col_end_s = new_col_end_s;
         eff_row_end_s = new_row_end_s;
      end else begin
         cur_col_s     = col_r;
         cur_row_s     = row_r;
      end
   end

   assign proc_s     = acc_s & (s_axis_tuser | (state_r == ST_ACTIVE));
   assign in_win_s   = ({1'b0, cur_row_s} >= {1'b0, eff_top_s}) & ({1'b0, cur_row_s} < eff_row_end_s) &
                       ({1'b0, cur_col_s} >= {1'b0, eff_left_s}) & ({1'b0, cur_col_s} < eff_col_end_s);
   assign first_s    = (cur_row_s == eff_top_s) & (cur_col_s == eff_left_s);
   assign last_s     = ({1'b0, cur_col_s} == (eff_col_end_s - ONE_WE)) | s_axis_tlast;
   assign row_last_s = s_axis_tlast & ({1'b0, cur_row_s} == (eff_row_end_s - ONE_HE));
   assign emit_s     = proc_s & in_win_s & ~soft_reset;

   // Frame sequencing: a start-of-frame pixel always restarts, the last window row ends the frame
   always_comb begin
      state_nxt_s = state_r;
      if (zero_win_s | row_last_s) begin
         sof_dest_s = ST_DONE;
      end else begin
         sof_dest_s = ST_ACTIVE;
      end
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (sof_s) begin
               state_nxt_s = sof_dest_s;
            end else begin
               state_nxt_s = state_r;
            end
         end
         ST_ACTIVE: begin
            if (sof_s) begin
               state_nxt_s = sof_dest_s;
            end else if (acc_s & row_last_s) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_ACTIVE;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State, pixel position and latched window
   always_ff @(posedge aclk or negedge resetn) begin
      if (!resetn) begin
         state_r   <= ST_IDLE;
         col_r     <= ZERO_W;
         row_r     <= ZERO_H;
         left_r    <= ZERO_W;
         top_r     <= ZERO_H;
         col_end_r <= ZERO_WE;
         row_end_r <= ZERO_HE;
      end else if (soft_reset) begin
         state_r   <= ST_IDLE;
         col_r     <= ZERO_W;
         row_r     <= ZERO_H;
      end else begin
         state_r <= state_nxt_s;
         if (proc_s) begin
            if (s_axis_tlast) begin
               col_r <= ZERO_W;
               row_r <= cur_row_s + ONE_H;
            end else begin
               col_r <= cur_col_s + ONE_W;
               row_r <= cur_row_s;
            end
         end
         if (sof_s) begin
            left_r    <= win_left;
            top_r     <= win_top;
            col_end_r <= new_col_end_s;
            row_end_r <= new_row_end_s;
         end
      end
   end

   // Single output stage; acceptance only happens when this stage is free or draining
   always_ff @(posedge aclk or negedge resetn) begin
      if (!resetn) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= {PW{1'b0}};
         m_axis_tuser  <= 1'b0;
         m_axis_tlast  <= 1'b0;
      end else if (soft_reset) begin
         m_axis_tvalid <= 1'b0;
      end else if (emit_s) begin
         m_axis_tvalid <= 1'b1;
         m_axis_tdata  <= s_axis_tdata;
         m_axis_tuser  <= first_s;
         m_axis_tlast  <= last_s;
      end else if (m_axis_tready) begin
         m_axis_tvalid <= 1'b0;
      end
   end

`ifdef AXIS_WINDOW_STAT_EN
   logic [15:0] frame_cnt_r;
   logic        sof_err_r;

   // Emitted-frame counter and sticky short-frame flag
   always_ff @(posedge aclk or negedge resetn) begin
      if (!resetn) begin
         frame_cnt_r <= 16'd0;
         sof_err_r   <= 1'b0;
      end else begin
         if (m_axis_tvalid & m_axis_tready & m_axis_tuser) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
         end
         if (soft_reset) begin
            sof_err_r <= 1'b0;
         end else if (sof_s & (state_r == ST_ACTIVE)) begin
            sof_err_r <= 1'b1;
         end
      end
   end

   assign frame_cnt = frame_cnt_r;
   assign sof_err   = sof_err_r;
`endif

endmodule

// File: tb/tb_axis_window.sv
// tb_axis_window: table-driven, hand-sequenced and random checks of axis_window against a frame-level model.
module tb_axis_window;

   logic        aclk = 1'b0;
   logic        resetn;
   logic        soft_reset;
   logic [11:0] win_left, win_top, win_width, win_height;
   logic        s_axis_tvalid, s_axis_tuser, s_axis_tlast, s_axis_tready;
   logic [7:0]  s_axis_tdata, m_axis_tdata;
   logic        m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tready;
`ifdef AXIS_WINDOW_STAT_EN
   logic [15:0] frame_cnt;
   logic        sof_err;
`endif

   always #5 aclk = ~aclk;

   axis_window dut (
      .aclk(aclk), .resetn(resetn), .soft_reset(soft_reset),
      .win_left(win_left), .win_top(win_top), .win_width(win_width), .win_height(win_height),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser),
      .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
      .m_axis_tlast(m_axis_tlast),
`ifdef AXIS_WINDOW_STAT_EN
      .frame_cnt(frame_cnt), .sof_err(sof_err),
`endif
      .m_axis_tready(m_axis_tready)
   );

   typedef struct {
      logic [7:0]  d;
      logic        u;
      logic        l;
      logic        srst;
      logic [11:0] left, top, w, h;
   } beat_t;

   typedef struct {
      logic [7:0] d;
      logic       u;
      logic       l;
   } obeat_t;

   typedef struct {
      int left, top, w, h, iw, ih, tmode;
      int n_out, n_last, n_user, first_d, last_d;
   } vec_t;

   beat_t  stim_q[$];
   obeat_t exp_q[$];
   int     frame_lens[$];
   int     n_checks = 0;
   int     n_err = 0;
   int     tready_mode = 0;
   int     valid_mode = 0;
   int     exp_frames = 0;
   int     obs_out, obs_last, obs_user, obs_first, obs_lastd;
   vec_t   vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Frame-level model: a pixel (r,c) is emitted iff it lies inside the window rectangle.
   task automatic add_frame(input bit trunc, input int left, input int top, input int w, input int h);
      beat_t  b;
      obeat_t e;
      int     nr;
      bit     eol, in_win;
      nr = frame_lens.size();
      for (int r = 0; r < nr; r++) begin
         for (int c = 0; c < frame_lens[r]; c++) begin
            eol    = (c == frame_lens[r] - 1) && !(trunc && (r == nr - 1));
            in_win = (r >= top) && (r < top + h) && (c >= left) && (c < left + w);
            b.d    = 8'(r * 16 + c);
            b.u    = (r == 0) && (c == 0);
            b.l    = eol;
            b.srst = 1'b0;
            b.left = b.u ? 12'(left) : 12'($urandom_range(0, 15));
            b.top  = b.u ? 12'(top)  : 12'($urandom_range(0, 15));
            b.w    = b.u ? 12'(w)    : 12'($urandom_range(0, 15));
            b.h    = b.u ? 12'(h)    : 12'($urandom_range(0, 15));
            stim_q.push_back(b);
            if (in_win) begin
               e.d = b.d;
               e.u = (r == top) && (c == left);
               e.l = (c == left + w - 1) || eol;
               exp_q.push_back(e);
               if (e.u) exp_frames++;
            end
         end
      end
   endtask

   // Beats without tuser; the first may carry a soft reset.
   task automatic add_junk(input int n, input bit with_srst);
      beat_t b;
      for (int i = 0; i < n; i++) begin
         b.d    = 8'($urandom_range(0, 255));
         b.u    = 1'b0;
         b.l    = 1'($urandom_range(0, 1));
         b.srst = with_srst && (i == 0);
         b.left = 12'($urandom_range(0, 15));
         b.top  = 12'($urandom_range(0, 15));
         b.w    = 12'($urandom_range(0, 15));
         b.h    = 12'($urandom_range(0, 15));
         stim_q.push_back(b);
      end
   endtask

   task automatic run_stream(input int max_cycles);
      int         cyc = 0;
      int         tail = 0;
      bit         prev_stall = 1'b0;
      bit         prev_srst = 1'b0;
      logic [9:0] held = 10'd0;
      obeat_t     e;
      obs_out = 0; obs_last = 0; obs_user = 0; obs_first = -1; obs_lastd = -1;
      while (cyc < max_cycles && (stim_q.size() > 0 || tail < 3)) begin
         @(negedge aclk);
         if (prev_srst) begin
            chk("srst_tvalid", 32'(m_axis_tvalid), 32'd0);
         end else if (prev_stall) begin
            chk("stall_hold", 32'({m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata}), 32'({1'b1, held}));
         end
         if (stim_q.size() > 0 && (valid_mode == 0 || $urandom_range(0, 3) != 0)) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = stim_q[0].d;
            s_axis_tuser  = stim_q[0].u;
            s_axis_tlast  = stim_q[0].l;
            soft_reset    = stim_q[0].srst;
            win_left      = stim_q[0].left;
            win_top       = stim_q[0].top;
            win_width     = stim_q[0].w;
            win_height    = stim_q[0].h;
         end else begin
            s_axis_tvalid = 1'b0;
            s_axis_tdata  = 8'($urandom_range(0, 255));
            s_axis_tuser  = 1'($urandom_range(0, 1));
            s_axis_tlast  = 1'($urandom_range(0, 1));
            soft_reset    = 1'b0;
         end
         if (stim_q.size() == 0) begin
            tail++;
            m_axis_tready = 1'b1;
         end else begin
            case (tready_mode)
               1:       m_axis_tready = (cyc % 2 == 0);
               2:       m_axis_tready = ($urandom_range(0, 2) != 0);
               default: m_axis_tready = 1'b1;
            endcase
         end
         #1;
         prev_srst = 1'b0;
         if (s_axis_tvalid && s_axis_tready) begin
            prev_srst = stim_q[0].srst;
            void'(stim_q.pop_front());
         end
         if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL extra_out: got data=0x%0h user=%0d last=%0d, expected no beat",
                        m_axis_tdata, m_axis_tuser, m_axis_tlast);
            end else begin
               e = exp_q.pop_front();
               chk("out_beat", 32'({m_axis_tuser, m_axis_tlast, m_axis_tdata}), 32'({e.u, e.l, e.d}));
            end
            obs_out++;
            if (m_axis_tlast) obs_last++;
            if (m_axis_tuser) obs_user++;
            if (obs_first < 0) obs_first = int'(m_axis_tdata);
            obs_lastd = int'(m_axis_tdata);
         end
         prev_stall = m_axis_tvalid && !m_axis_tready;
         held = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
         cyc++;
      end
      s_axis_tvalid = 1'b0;
      soft_reset    = 1'b0;
      if (cyc >= max_cycles) begin
         n_checks++;
         n_err++;
         $display("FAIL stream_timeout: %0d beats still queued after %0d cycles", stim_q.size(), cyc);
         stim_q.delete();
      end
      chk("exp_drained", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      //            left top  w  h iw ih tm  out last user first last
      vecs[0] = '{2, 1, 3, 2, 8, 4, 0,  6, 2, 1, 18, 36};
      vecs[1] = '{2, 1, 3, 2, 8, 4, 1,  6, 2, 1, 18, 36};
      vecs[2] = '{6, 1, 4, 2, 8, 4, 0,  4, 2, 1, 22, 39};
      vecs[3] = '{2, 1, 0, 2, 8, 4, 0,  0, 0, 0, -1, -1};
      vecs[4] = '{2, 1, 3, 0, 8, 4, 0,  0, 0, 0, -1, -1};
      vecs[5] = '{0, 0, 8, 4, 8, 4, 1, 32, 4, 1,  0, 55};
      vecs[6] = '{7, 3, 1, 5, 8, 4, 0,  1, 1, 1, 55, 55};
      vecs[7] = '{9, 0, 2, 2, 8, 4, 0,  0, 0, 0, -1, -1};
      vecs[8] = '{0, 4, 3, 1, 8, 4, 0,  0, 0, 0, -1, -1};
      vecs[9] = '{1, 2, 2, 1, 8, 4, 1,  2, 1, 1, 33, 34};

      resetn = 1'b0; soft_reset = 1'b0;
      win_left = 12'd0; win_top = 12'd0; win_width = 12'd0; win_height = 12'd0;
      s_axis_tvalid = 1'b0; s_axis_tdata = 8'd0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
      m_axis_tready = 1'b1;
      repeat (2) @(negedge aclk);
      chk("reset_outputs", 32'({m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata, s_axis_tready}), 32'd0);
`ifdef AXIS_WINDOW_STAT_EN
      chk("reset_stats", 32'({frame_cnt, sof_err}), 32'd0);
`endif
      resetn = 1'b1;
      #1;
      chk("reset_release", 32'({s_axis_tready, m_axis_tvalid}), 32'b10);

      // Table-driven whole-frame vectors
      for (int i = 0; i < 10; i++) begin
         frame_lens.delete();
         for (int r = 0; r < vecs[i].ih; r++) frame_lens.push_back(vecs[i].iw);
         tready_mode = vecs[i].tmode;
         valid_mode  = 0;
         add_frame(1'b0, vecs[i].left, vecs[i].top, vecs[i].w, vecs[i].h);
         run_stream(2000);
         chk($sformatf("vec%0d_count", i), 32'(obs_out), 32'(vecs[i].n_out));
         chk($sformatf("vec%0d_tlasts", i), 32'(obs_last), 32'(vecs[i].n_last));
         chk($sformatf("vec%0d_tusers", i), 32'(obs_user), 32'(vecs[i].n_user));
         chk($sformatf("vec%0d_first", i), 32'(obs_first), 32'(vecs[i].first_d));
         chk($sformatf("vec%0d_lastpx", i), 32'(obs_lastd), 32'(vecs[i].last_d));
      end

      // Soft reset during row 1: rest of that frame dropped, next frame crops normally
      tready_mode = 0; valid_mode = 0;
      frame_lens = {8, 3};
      add_frame(1'b1, 2, 1, 3, 2);
      add_junk(1 + 4 + 16, 1'b1);
      frame_lens = {8, 8, 8, 8};
      add_frame(1'b0, 2, 1, 3, 2);
      run_stream(2000);
`ifdef AXIS_WINDOW_STAT_EN
      chk("sof_err_cleared", 32'(sof_err), 32'd0);
`endif

      // tuser injected at row 1 col 3 restarts with a new window
      frame_lens = {8, 3};
      add_frame(1'b1, 2, 1, 3, 2);
      frame_lens = {8, 8, 8, 8};
      add_frame(1'b0, 1, 0, 2, 1);
      run_stream(2000);
      chk("inject_tusers", 32'(obs_user), 32'd2);
      chk("inject_lastpx", 32'(obs_lastd), 32'h02);
`ifdef AXIS_WINDOW_STAT_EN
      chk("sof_err_set", 32'(sof_err), 32'd1);
      chk("frame_cnt", 32'(frame_cnt), 32'(16'(exp_frames)));
`endif

      // Hard reset mid-frame while an output is stalled
      @(negedge aclk);
      s_axis_tvalid = 1'b1; s_axis_tdata = 8'hA5; s_axis_tuser = 1'b1; s_axis_tlast = 1'b0;
      win_left = 12'd0; win_top = 12'd0; win_width = 12'd4; win_height = 12'd4;
      m_axis_tready = 1'b0;
      @(negedge aclk);
      s_axis_tvalid = 1'b0;
      chk("pre_reset_out", 32'({m_axis_tvalid, m_axis_tuser, m_axis_tdata}), 32'({1'b1, 1'b1, 8'hA5}));
      #1 resetn = 1'b0;
      m_axis_tready = 1'b1;
      #1;
      chk("async_reset_out", 32'({m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata, s_axis_tready}), 32'd0);
      @(negedge aclk);
      chk("reset_tready_low", 32'(s_axis_tready), 32'd0);
`ifdef AXIS_WINDOW_STAT_EN
      chk("reset_stats_mid", 32'({frame_cnt, sof_err}), 32'd0);
`endif
      resetn = 1'b1;
      exp_frames = 0;
      #1;
      chk("reset_tready_high", 32'(s_axis_tready), 32'd1);

      // Random frames with random valid/ready, short lines and short frames
      tready_mode = 2; valid_mode = 1;
      add_junk($urandom_range(0, 5), 1'b0);
      for (int f = 0; f < 40; f++) begin
         frame_lens.delete();
         for (int r = 0; r < $urandom_range(1, 6); r++) frame_lens.push_back($urandom_range(1, 10));
         add_frame($urandom_range(0, 3) == 0, $urandom_range(0, 10), $urandom_range(0, 6),
                   $urandom_range(0, 6), $urandom_range(0, 4));
      end
      run_stream(20000);
`ifdef AXIS_WINDOW_STAT_EN
      chk("frame_cnt_random", 32'(frame_cnt), 32'(16'(exp_frames)));
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
